// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry front end.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam int KEY_ENTER  = 0;
  localparam int KEY_CANCEL = 1;

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low pushbutton, debounces it, and flags debounced presses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic fall_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser, stability counter and registered fall detect.
  // The level moves once DEBOUNCE_CYCLES differing samples have been counted
  // and the next sample still differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      fall_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw_n;
      sync2_r <= sync1_r;
      fall_r  <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CW'(DEBOUNCE_CYCLES)) begin
          level_r <= sync2_r;
          fall_r  <= ~sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign level      = level_r;
  assign fall_pulse = fall_r;

endmodule

// File: rtl/operand_entry_fsm.sv
// Two-operand entry from switches: KEY0 captures A then B, KEY1 cancels.
module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic [1:0]       KEY,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic             load_pulse,
  output logic [1:0]       entry_state
);

  // Arming waits long enough that a key held through reset has already
  // debounced low, so its stale press is never seen as armed.
  localparam int ARM_WAIT = DEBOUNCE_CYCLES + 4;
  localparam int AW       = $clog2(ARM_WAIT + 1);

  logic             enter_level_s, enter_fall_s;
  logic             cancel_level_s, cancel_fall_s;
  logic             enter_s, cancel_s;
  logic [WIDTH-1:0] sw_meta_r, sw_sync_r;
  logic [WIDTH-1:0] op_a_r, op_b_r;
  logic             valid_r, load_r, arm_r;
  logic [AW-1:0]    arm_cnt_r;
  state_t           state_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clk        (MAX10_CLK1_50),
    .rst        (rst),
    .raw_n      (KEY[KEY_ENTER]),
    .level      (enter_level_s),
    .fall_pulse (enter_fall_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cancel (
    .clk        (MAX10_CLK1_50),
    .rst        (rst),
    .raw_n      (KEY[KEY_CANCEL]),
    .level      (cancel_level_s),
    .fall_pulse (cancel_fall_s)
  );

  assign enter_s  = enter_fall_s & arm_r;
  assign cancel_s = cancel_fall_s & arm_r;

  // Switch synchroniser and post-reset arming on both keys released.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      sw_meta_r <= {WIDTH{1'b0}};
      sw_sync_r <= {WIDTH{1'b0}};
      arm_r     <= 1'b0;
      arm_cnt_r <= {AW{1'b0}};
    end else begin
      sw_meta_r <= SW;
      sw_sync_r <= sw_meta_r;
      if (enter_level_s && cancel_level_s) begin
        if (arm_cnt_r == AW'(ARM_WAIT)) begin
          arm_r <= 1'b1;
        end else begin
          arm_cnt_r <= arm_cnt_r + AW'(1);
        end
      end else begin
        arm_cnt_r <= {AW{1'b0}};
      end
    end
  end

  // Entry state machine with registered operands and indicators.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_r <= ENTER_A;
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      load_r  <= 1'b0;
    end else begin
      load_r <= 1'b0;
      if (cancel_s) begin
        state_r <= ENTER_A;
        op_a_r  <= {WIDTH{1'b0}};
        op_b_r  <= {WIDTH{1'b0}};
        valid_r <= 1'b0;
      end else if (enter_s) begin
        case (state_r)
          ENTER_A: begin
            op_a_r  <= sw_sync_r;
            state_r <= ENTER_B;
            valid_r <= 1'b0;
          end
          ENTER_B: begin
            op_b_r  <= sw_sync_r;
            state_r <= SHOW;
            valid_r <= 1'b1;
            load_r  <= 1'b1;
          end
          SHOW: begin
            state_r <= ENTER_A;
            valid_r <= 1'b0;
          end
          default: begin
            state_r <= ENTER_A;
            valid_r <= 1'b0;
          end
        endcase
      end else begin
        case (state_r)
          ENTER_A, ENTER_B, SHOW: begin
            state_r <= state_r;
            valid_r <= (state_r == SHOW);
          end
          default: begin
            state_r <= ENTER_A;
            valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign op_a           = op_a_r;
  assign op_b           = op_b_r;
  assign operands_valid = valid_r;
  assign load_pulse     = load_r;
  assign entry_state    = state_r;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a short debounce window.
module tb_operand_entry_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic [3:0] SW;
  logic [3:0] op_a, op_b;
  logic       operands_valid, load_pulse;
  logic [1:0] entry_state;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int load_cnt  = 0;

  operand_entry_fsm #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .MAX10_CLK1_50  (clk),
    .rst            (rst),
    .KEY            (KEY),
    .SW             (SW),
    .op_a           (op_a),
    .op_b           (op_b),
    .operands_valid (operands_valid),
    .load_pulse     (load_pulse),
    .entry_state    (entry_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (load_pulse) load_cnt++;
    end
  endtask

  task automatic press(input logic [3:0] sw_val);
    SW     = sw_val;
    KEY[0] = 1'b0;
    hold(10);
    KEY[0] = 1'b1;
    hold(10);
  endtask

  task automatic cancel();
    KEY[1] = 1'b0;
    hold(10);
    KEY[1] = 1'b1;
    hold(10);
  endtask

  initial begin
    int first_k;
    int pulses;
    rst = 1'b1;
    KEY = 2'b11;
    SW  = 4'h0;
    hold(3);
    chk("rst_state", entry_state, 2'd0);
    chk("rst_op_a", op_a, 4'h0);
    chk("rst_op_b", op_b, 4'h0);
    chk("rst_valid", operands_valid, 1'b0);
    chk("rst_load", load_pulse, 1'b0);
    rst = 1'b0;
    hold(12);

    // 1: enter 9 then 3
    press(4'h9);
    chk("t1_op_a", op_a, 4'h9);
    chk("t1_state_b", entry_state, 2'd1);
    load_cnt = 0;
    press(4'h3);
    chk("t1_op_b", op_b, 4'h3);
    chk("t1_load_once", load_cnt, 1);
    chk("t1_valid", operands_valid, 1'b1);
    chk("t1_state_show", entry_state, 2'd2);

    // cancel from SHOW clears everything
    cancel();
    chk("cancel_state", entry_state, 2'd0);
    chk("cancel_op_a", op_a, 4'h0);
    chk("cancel_op_b", op_b, 4'h0);
    chk("cancel_valid", operands_valid, 1'b0);

    // 2: bounce shorter than the debounce window
    SW = 4'hA;
    KEY[0] = 1'b0; hold(2);
    KEY[0] = 1'b1; hold(1);
    KEY[0] = 1'b0; hold(2);
    KEY[0] = 1'b1; hold(12);
    chk("t2_bounce_state", entry_state, 2'd0);
    chk("t2_bounce_op_a", op_a, 4'h0);
    first_k = -1;
    pulses  = 0;
    KEY[0]  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (dut.u_key_enter.fall_pulse) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    KEY[0] = 1'b1;
    hold(10);
    // first low sample at k=1, pulse six cycles later
    chk("t2_pulse_k", first_k, 7);
    chk("t2_pulse_count", pulses, 1);
    chk("t2_op_a", op_a, 4'hA);
    chk("t2_state", entry_state, 2'd1);

    // 3: simultaneous enter and cancel in ENTER_B with op_a = 5
    cancel();
    press(4'h5);
    chk("t3_pre_op_a", op_a, 4'h5);
    chk("t3_pre_state", entry_state, 2'd1);
    load_cnt = 0;
    SW  = 4'hE;
    KEY = 2'b00;
    hold(10);
    KEY = 2'b11;
    hold(10);
    chk("t3_state", entry_state, 2'd0);
    chk("t3_op_a", op_a, 4'h0);
    chk("t3_op_b", op_b, 4'h0);
    chk("t3_no_load", load_cnt, 0);

    // 5: leaving SHOW keeps the operands
    press(4'h2);
    press(4'h7);
    chk("t5_valid", operands_valid, 1'b1);
    SW = 4'hC;
    first_k = -1;
    KEY[0]  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (!operands_valid && first_k < 0) first_k = k;
    end
    KEY[0] = 1'b1;
    hold(10);
    chk("t5_valid_drop_k", first_k, 8);
    chk("t5_state", entry_state, 2'd0);
    chk("t5_op_a", op_a, 4'h2);
    chk("t5_op_b", op_b, 4'h7);
    for (int i = 0; i < 8; i++) begin
      SW = 4'(i * 3);
      hold(3);
    end
    chk("t5_sw_op_a", op_a, 4'h2);
    chk("t5_sw_op_b", op_b, 4'h7);

    // 4: KEY0 held through reset
    SW     = 4'hF;
    KEY[0] = 1'b0;
    rst    = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(20);
    chk("t4_held_state", entry_state, 2'd0);
    chk("t4_held_op_a", op_a, 4'h0);
    KEY[0] = 1'b1;
    hold(20);
    press(4'hF);
    chk("t4_op_a", op_a, 4'hF);
    chk("t4_state", entry_state, 2'd1);

    // 6: reset while the debounce counter is at 3
    KEY[0] = 1'b0;
    hold(5);
    chk("t6_cnt_at_3", dut.u_key_enter.cnt_r, 3);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    chk("t6_op_a", op_a, 4'h0);
    chk("t6_state", entry_state, 2'd0);
    chk("t6_valid", operands_valid, 1'b0);
    hold(20);
    chk("t6_no_press", entry_state, 2'd0);
    KEY[0] = 1'b1;
    hold(20);
    press(4'h6);
    chk("t6_op_a_new", op_a, 4'h6);
    chk("t6_state_new", entry_state, 2'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
